// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 multicycle control unit:
// opcodes, controller state encoding and data-memory modes.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] MEM_RD   = 2'd0;
  localparam logic [1:0] MEM_IND  = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;
  localparam logic [1:0] MEM_IDLE = 2'd3;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM_IND,
    S_MEM_READ,
    S_MEM_WRITE,
    S_WRITEBACK,
    S_UPDATE_PC
  } state_e;

endpackage

// File: rtl/lc3_ctrl_timeout.sv
// Wait-state cycle counter. clr_i zeroes it, en_i advances it,
// expire_o flags the LIMIT-th consecutive enabled cycle.
// Ports: clock, reset, clr_i, en_i -> expire_o.
module lc3_ctrl_timeout #(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Count starts at 0 in the first wait cycle, so LIMIT-1
  // marks the last cycle the FSM may spend waiting.
  assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/lc3_controller.sv
// LC-3 multicycle controller: fetch/decode/execute/mem/wb/pc.
// Ports: clock, reset, complete_instr, complete_data, ir, psr ->
//   stage enables, br_taken, mem_state, timeout_err.
// Optional wait timeout enabled by macro LC3_CTRL_TIMEOUT_EN.
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        enable_updatepc,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        timeout_err
);

  state_e     state_q, state_d;
  logic [3:0] op;
  logic       to_expire;
  logic       take_to;
  logic       skip;
  logic       unused_ok;

  assign op = ir[15:12];
  assign unused_ok = ^ir[8:0] ^ (TIMEOUT_CYCLES == 0);

  always_comb begin
    state_d = state_q;
    take_to = 1'b0;
    unique case (state_q)
      S_RST:       state_d = S_FETCH;
      S_FETCH: begin
        if (complete_instr) begin
          state_d = S_DECODE;
        end else if (to_expire) begin
          state_d = S_UPDATE_PC;
          take_to = 1'b1;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        unique case (op)
          OP_ADD, OP_AND,
          OP_NOT, OP_LEA: state_d = S_WRITEBACK;
          OP_LD, OP_LDR:  state_d = S_MEM_READ;
          OP_LDI, OP_STI: state_d = S_MEM_IND;
          OP_ST, OP_STR:  state_d = S_MEM_WRITE;
          default:        state_d = S_UPDATE_PC;
        endcase
      end
      S_MEM_IND: begin
        if (complete_data) begin
          state_d = (op == OP_LDI) ? S_MEM_READ
                                   : S_MEM_WRITE;
        end else if (to_expire) begin
          state_d = S_UPDATE_PC;
          take_to = 1'b1;
        end
      end
      S_MEM_READ: begin
        if (complete_data) begin
          state_d = S_WRITEBACK;
        end else if (to_expire) begin
          state_d = S_UPDATE_PC;
          take_to = 1'b1;
        end
      end
      S_MEM_WRITE: begin
        if (complete_data || to_expire)
          state_d = S_UPDATE_PC;
        take_to = !complete_data && to_expire;
      end
      S_WRITEBACK: state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_FETCH;
      default:     state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state_q <= S_RST;
    else
      state_q <= state_d;
  end

`ifdef LC3_CTRL_TIMEOUT_EN
  logic waiting;
  logic skip_q, skip_d;
  logic err_q, err_d;

  assign waiting = (state_q == S_FETCH)
                || (state_q == S_MEM_IND)
                || (state_q == S_MEM_READ)
                || (state_q == S_MEM_WRITE);

  // Any state change clears, so each wait state starts at 0.
  lc3_ctrl_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (state_d != state_q),
    .en_i     (waiting),
    .expire_o (to_expire)
  );

  // A timed-out instruction still passes UPDATE_PC but must
  // not branch, whatever stale value ir holds.
  always_comb begin
    skip_d = skip_q;
    if (take_to)
      skip_d = 1'b1;
    else if (state_q == S_UPDATE_PC)
      skip_d = 1'b0;
    err_d = err_q | take_to;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skip_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      skip_q <= skip_d;
      err_q  <= err_d;
    end
  end

  assign skip        = skip_q;
  assign timeout_err = err_q;
`else
  assign to_expire   = 1'b0;
  assign skip        = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    enable_fetch     = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    enable_updatepc  = 1'b0;
    br_taken         = 1'b0;
    mem_state        = MEM_IDLE;
    unique case (state_q)
      S_FETCH:     enable_fetch     = 1'b1;
      S_DECODE:    enable_decode    = 1'b1;
      S_EXECUTE:   enable_execute   = 1'b1;
      S_MEM_IND:   mem_state        = MEM_IND;
      S_MEM_READ:  mem_state        = MEM_RD;
      S_MEM_WRITE: mem_state        = MEM_WR;
      S_WRITEBACK: enable_writeback = 1'b1;
      S_UPDATE_PC: begin
        enable_updatepc = 1'b1;
        if (!skip) begin
          if (op == OP_BR)
            br_taken = |(ir[11:9] & psr);
          else if (op == OP_JMP)
            br_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_controller.sv
// Directed self-checking bench for lc3_controller.
// Observes {fetch,decode,exec,wb,updpc,br,mem_state} per cycle.
module tb_lc3_controller;

  logic        clock;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatepc;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        timeout_err;

  int checks = 0;
  int passes = 0;

  localparam logic [7:0] F  = 8'b10000_0_11;
  localparam logic [7:0] D  = 8'b01000_0_11;
  localparam logic [7:0] E  = 8'b00100_0_11;
  localparam logic [7:0] W  = 8'b00010_0_11;
  localparam logic [7:0] U  = 8'b00001_0_11;
  localparam logic [7:0] UB = 8'b00001_1_11;
  localparam logic [7:0] I  = 8'b00000_0_01;
  localparam logic [7:0] R  = 8'b00000_0_00;
  localparam logic [7:0] MW = 8'b00000_0_10;
  localparam logic [7:0] Z  = 8'b00000_0_11;

  lc3_controller #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .ir               (ir),
    .psr              (psr),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .enable_updatepc  (enable_updatepc),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .timeout_err      (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] obs();
    return {enable_fetch, enable_decode, enable_execute,
            enable_writeback, enable_updatepc, br_taken,
            mem_state};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    complete_instr = 1'b0;
    complete_data = 1'b0;
    ir = 16'h0000;
    psr = 3'b000;
    #1;
    checks++;
    if (obs() !== Z)
      $display("FAIL reset_outs: got %b want %b", obs(), Z);
    else passes++;
    checks++;
    if (timeout_err !== 1'b0)
      $display("FAIL reset_err: got %b want 0", timeout_err);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (obs() !== Z)
      $display("FAIL rst_state: got %b want %b", obs(), Z);
    else passes++;
    @(negedge clock);
    checks++;
    if (obs() !== F)
      $display("FAIL first_fetch: got %b want %b", obs(), F);
    else passes++;
  endtask

  task automatic test_add();
    logic [7:0] ex [5] = '{F, D, E, W, U};
    ir = 16'h1042;
    for (int i = 0; i < 5; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex[i])
        $display("FAIL add c%0d: got %b want %b",
                 i, obs(), ex[i]);
      else passes++;
      @(negedge clock);
    end
    complete_instr = 1'b0;
    checks++;
    if (obs() !== F)
      $display("FAIL add_next: got %b want %b", obs(), F);
    else passes++;
  endtask

  task automatic test_br();
    logic [7:0] ex_t [4] = '{F, D, E, UB};
    logic [7:0] ex_n [4] = '{F, D, E, U};
    ir = 16'h0405;
    psr = 3'b010;
    for (int i = 0; i < 4; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex_t[i])
        $display("FAIL brz_taken c%0d: got %b want %b",
                 i, obs(), ex_t[i]);
      else passes++;
      @(negedge clock);
    end
    psr = 3'b001;
    for (int i = 0; i < 4; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex_n[i])
        $display("FAIL brz_not c%0d: got %b want %b",
                 i, obs(), ex_n[i]);
      else passes++;
      @(negedge clock);
    end
    ir = 16'hC1C0;
    psr = 3'b000;
    for (int i = 0; i < 4; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex_t[i])
        $display("FAIL jmp c%0d: got %b want %b",
                 i, obs(), ex_t[i]);
      else passes++;
      @(negedge clock);
    end
    complete_instr = 1'b0;
    checks++;
    if (obs() !== F)
      $display("FAIL br_next: got %b want %b", obs(), F);
    else passes++;
  endtask

  task automatic test_ldi();
    logic [7:0] ex [11] =
      '{F, D, E, I, I, I, R, R, R, W, U};
    logic       cd [11] =
      '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    ir = 16'hA202;
    for (int i = 0; i < 11; i++) begin
      complete_instr = (i == 0);
      complete_data = cd[i];
      checks++;
      if (obs() !== ex[i])
        $display("FAIL ldi c%0d: got %b want %b",
                 i, obs(), ex[i]);
      else passes++;
      @(negedge clock);
    end
    complete_instr = 1'b0;
    complete_data = 1'b0;
    checks++;
    if (obs() !== F)
      $display("FAIL ldi_next: got %b want %b", obs(), F);
    else passes++;
  endtask

  // complete_instr in DECODE and complete_data in EXECUTE
  // arrive where nothing waits on them and must be ignored.
  task automatic test_str();
    logic [7:0] ex [6] = '{F, D, E, MW, MW, U};
    logic       ci [6] = '{1, 1, 0, 0, 0, 0};
    logic       cd [6] = '{0, 0, 1, 0, 1, 0};
    ir = 16'h7041;
    for (int i = 0; i < 6; i++) begin
      complete_instr = ci[i];
      complete_data = cd[i];
      checks++;
      if (obs() !== ex[i])
        $display("FAIL str c%0d: got %b want %b",
                 i, obs(), ex[i]);
      else passes++;
      @(negedge clock);
    end
    complete_instr = 1'b0;
    complete_data = 1'b0;
    checks++;
    if (obs() !== F)
      $display("FAIL str_next: got %b want %b", obs(), F);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] ex [4] = '{F, D, E, R};
    ir = 16'h2005;
    for (int i = 0; i < 4; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex[i])
        $display("FAIL ld_pre c%0d: got %b want %b",
                 i, obs(), ex[i]);
      else passes++;
      if (i < 3) @(negedge clock);
    end
    complete_instr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs() !== Z)
      $display("FAIL mid_reset: got %b want %b", obs(), Z);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (obs() !== F)
      $display("FAIL resume: got %b want %b", obs(), F);
    else passes++;
    // Complete the fetch so later tests start aligned.
    complete_instr = 1'b1;
    ir = 16'h0000;
    @(negedge clock);
    complete_instr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (obs() !== U)
      $display("FAIL nop_upd: got %b want %b", obs(), U);
    else passes++;
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b0)
      $display("FAIL err_clear: got %b want 0", timeout_err);
    else passes++;
  endtask

`ifdef LC3_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] ex [12] =
      '{F, D, E, R, R, R, R, R, R, R, R, U};
    ir = 16'h2003;
    psr = 3'b111;
    complete_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      complete_instr = (i == 0);
      checks++;
      if (obs() !== ex[i])
        $display("FAIL timeout c%0d: got %b want %b",
                 i, obs(), ex[i]);
      else passes++;
      @(negedge clock);
    end
    complete_instr = 1'b0;
    checks++;
    if (obs() !== F || timeout_err !== 1'b1)
      $display("FAIL to_err: got %b/%b want %b/1",
               obs(), timeout_err, F);
    else passes++;
    ir = 16'h0405;
    psr = 3'b010;
    complete_instr = 1'b1;
    @(negedge clock);
    complete_instr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (obs() !== UB)
      $display("FAIL br_after_to: got %b want %b", obs(), UB);
    else passes++;
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1)
      $display("FAIL err_sticky: got %b want 1", timeout_err);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_br();
    test_ldi();
    test_str();
    test_reset_mid();
`ifdef LC3_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
